// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per clock, with sign and exception applied at completion.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] p;
    logic               neg;

    logic               start, last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] p_step, prod;
    logic [WIDTH-1:0]   quo, res_next;
    logic               exc_next;

    assign start = ctrl_MULT | ctrl_DIV;
    assign last  = (cnt == CNT_W'(WIDTH));
    assign busy  = (state == MUL) || (state == DIV);
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ctrl_MULT) begin
            state_next = MUL;
        end else if (ctrl_DIV) begin
            state_next = DIV;
        end else begin
            case (state)
                MUL, DIV: if (last) state_next = DONE;
                DONE:     state_next = IDLE;
                default:  state_next = state;
            endcase
        end
    end

    // p holds {accumulator, multiplier} when multiplying and {remainder, quotient} when dividing
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_reg} : '0);
        rem_shift = p[2*WIDTH-1:WIDTH-1];
        rem_ge    = (rem_shift >= {1'b0, b_reg});
        rem_diff  = rem_shift - {1'b0, b_reg};
        prod      = neg ? -p : p;
        quo       = neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        p_step    = p;
        res_next  = '0;
        exc_next  = 1'b0;
        if (state == MUL) begin
            p_step   = {mul_sum, p[WIDTH-1:1]};
            res_next = prod[WIDTH-1:0];
            exc_next = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        end else if (state == DIV) begin
            p_step = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]), p[WIDTH-2:0], rem_ge};
            if (b_reg == '0) begin
                res_next = '0;
                exc_next = 1'b1;
            end else begin
                // only a positive quotient of magnitude 2^(WIDTH-1) is unrepresentable
                res_next = quo;
                exc_next = !neg && p[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            cnt            <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            p              <= '0;
            neg            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (start) begin
            cnt            <= '0;
            a_reg          <= mag_a;
            b_reg          <= mag_b;
            neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            p              <= ctrl_MULT ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
            data_resultRDY <= 1'b0;
        end else if (busy) begin
            if (last) begin
                data_result    <= res_next;
                data_exception <= exc_next;
                data_resultRDY <= 1'b1;
            end else begin
                p   <= p_step;
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            data_resultRDY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: fixed vectors, random operations against an
// arithmetic reference model, and hand-written abort/back-to-back/reset sequences.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        clr, ctrl_MULT, ctrl_DIV;
    logic [31:0] A, B;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks   = 0;
    int failures = 0;

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(A), .data_operandB(B), .data_result(data_result),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic, result is the low word, exception on range loss
    function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
        int     ia, ib;
        longint la, lb, pr, q;
        logic   e;
        logic [31:0] r;
        ia = a; ib = b;
        la = ia; lb = ib;
        if (m) begin
            pr = la * lb;
            r  = pr[31:0];
            e  = (pr != longint'(int'(pr)));
        end else if (ib == 0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            q = la / lb;
            r = q[31:0];
            e = (q > 64'sd2147483647);
        end
        return {e, r};
    endfunction

    // Called at a negedge; returns at the negedge after the start edge E0
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT = m; ctrl_DIV = d; A = a; B = b;
        @(posedge clock); @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        A = $urandom; B = $urandom;
    endtask

    task automatic wait_rdy(output int lat, output int busy_low);
        lat = -1;
        busy_low = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock); @(negedge clock);
            if (data_resultRDY) begin
                lat = n;
                break;
            end
            if (!busy) busy_low++;
        end
    endtask

    task automatic run_op(input string name, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic e);
        int lat, bl;
        logic [31:0] held;
        start_op(m, d, a, b);
        wait_rdy(lat, bl);
        chk({name, " latency"}, lat, 33);
        chk({name, " busy during op"}, bl, 0);
        chk({name, " result"}, data_result, r);
        chk({name, " exception"}, {31'd0, data_exception}, {31'd0, e});
        chk({name, " busy at done"}, {31'd0, busy}, 32'd0);
        held = data_result;
        @(posedge clock); @(negedge clock);
        chk({name, " rdy drop"}, {31'd0, data_resultRDY}, 32'd0);
        chk({name, " result hold"}, data_result, held);
    endtask

    initial begin
        logic [32:0] exp;
        logic [31:0] ra, rb, hold_r;
        logic        rm, rd;
        int          lat, bl, strobes, first;
        logic [31:0] pool[6];
        string       nm;

        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFFFFFF;
        pool[3] = 32'h80000000; pool[4] = 32'h7FFFFFFF; pool[5] = 32'h0000FFFF;

        vecs[0] = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h00000000, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};

        clr = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; A = '0; B = '0;
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clock); @(negedge clock);
        clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            nm = $sformatf("vec%0d", i);
            run_op(nm, vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);
        end

        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = $urandom_range(0, 40) - 20;
            case ($urandom_range(0, 2))
                0:       begin rm = 1'b1; rd = 1'b0; end
                1:       begin rm = 1'b0; rd = 1'b1; end
                default: begin rm = 1'b1; rd = 1'b1; end
            endcase
            exp = model(rm, ra, rb);
            nm = $sformatf("rand%0d", i);
            run_op(nm, rm, rd, ra, rb, exp[31:0], exp[32]);
        end

        // Back-to-back: new start sampled on the edge ending the DONE cycle
        start_op(1'b1, 1'b0, 32'd9, 32'hFFFFFFFD);
        wait_rdy(lat, bl);
        chk("b2b first latency", lat, 33);
        chk("b2b first result", data_result, 32'hFFFFFFE5);
        start_op(1'b0, 1'b1, 32'd1000, 32'hFFFFFFF6);
        wait_rdy(lat, bl);
        chk("b2b second latency", lat, 33);
        chk("b2b second result", data_result, 32'hFFFFFF9C);
        @(posedge clock); @(negedge clock);

        // Abort by restart: multiply replaced by a divide 10 edges later
        strobes = 0;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        for (int n = 0; n < 9; n++) begin
            @(posedge clock); @(negedge clock);
            if (data_resultRDY) strobes++;
        end
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        first = -1;
        hold_r = '0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clock); @(negedge clock);
            if (data_resultRDY) begin
                strobes++;
                if (first < 0) begin
                    first = n;
                    hold_r = data_result;
                    chk("abort exception", {31'd0, data_exception}, 32'd0);
                end
            end
        end
        chk("abort strobe count", strobes, 1);
        chk("abort latency", first, 33);
        chk("abort result", hold_r, 32'd14);

        // clr in the middle of a multiply, at edge E20
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (19) begin @(posedge clock); @(negedge clock); end
        @(posedge clock);
        #2 clr = 1'b1;
        #1;
        chk("clr result", data_result, 32'd0);
        chk("clr exception", {31'd0, data_exception}, 32'd0);
        chk("clr rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("clr busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        clr = 1'b0;
        strobes = 0;
        repeat (40) begin
            @(posedge clock); @(negedge clock);
            if (data_resultRDY) strobes++;
        end
        chk("clr no strobe", strobes, 0);
        run_op("both pulses", 1'b1, 1'b1, 32'd2, 32'd3, 32'd6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit, one clock domain.
- Sits directly upstream of the 32-bit writeback register: its data_result/data_resultRDY pair drives that register's w/w_en.
- Operation is started by a one-cycle control pulse.
- After a fixed latency it presents the result, an exception flag and a one-cycle ready strobe.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 4.
- CNT_W, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clock  input  1  rising-edge clock
- clr  input  1  asynchronous active-high reset
- ctrl_MULT  input  1  start-multiply pulse; sampled each rising edge
- ctrl_DIV  input  1  start-divide pulse; sampled each rising edge
- data_operandA  input  WIDTH  multiplicand/dividend, two's complement
- data_operandB  input  WIDTH  multiplier/divisor, two's complement
- data_result  output  WIDTH  product low word or quotient, registered
- data_exception  output  1  overflow or divide-by-zero flag, registered
- data_resultRDY  output  1  one-cycle ready strobe, registered
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset values:
  - Asynchronous clr forces state IDLE, counter 0 and all internal operand registers 0.
  - Outputs reset to data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- States:
  - IDLE, MUL, DIV, DONE.
  - Any state -> MUL on ctrl_MULT=1.
  - Any state -> DIV on ctrl_DIV=1 with ctrl_MULT=0.
  - MUL/DIV -> DONE after WIDTH iterations.
  - DONE -> IDLE on the next edge when no start is present.
- Start (edge E0):
  - Latch data_operandA/B.
  - Clear the counter.
  - Set busy=1.
  - Clear data_resultRDY.
  - data_result and data_exception keep their previous values until DONE.
- Priority: ctrl_MULT and ctrl_DIV both high -> multiply.
- Start while busy or in DONE: abort the current operation with no ready strobe for it, then restart with the new operands. This restart rule applies in every state.
- Multiply:
  - Shift-add on operand magnitudes, one bit per edge, edges E1..E_WIDTH.
  - Sign applied at completion.
  - data_result = low WIDTH bits of the signed 2*WIDTH-bit product.
  - data_exception=1 iff the full product is not representable in signed WIDTH bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per edge, edges E1..E_WIDTH.
  - Quotient truncates toward zero; sign = signA XOR signB. The remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1, with the same full latency.
  - Dividend -2^(WIDTH-1) with divisor -1: data_result=0x80000000 (for WIDTH=32), data_exception=1.
- Completion at edge E_(WIDTH+1), i.e. 33 edges after the start edge for WIDTH=32:
  - data_result and data_exception are updated.
  - data_resultRDY=1 and busy=0.
- data_resultRDY is high for exactly one cycle and drops at the next edge. data_result and data_exception stay stable until the next completion or clr.
- Operand inputs are don't-care after E0; changing them mid-operation has no effect.
- clr mid-operation: the operation is lost and no strobe is issued. The unit accepts a new start on the first edge after clr deasserts.
- Back-to-back: a start pulse during the DONE cycle is accepted. RDY still asserts for that DONE cycle, and the new operation completes 33 edges later.

Test Plan:
- ctrl_MULT pulse, A=7, B=-6 (0xFFFFFFFA):
  - data_resultRDY=1 exactly one cycle, 33 edges after the start edge.
  - data_result=0xFFFFFFD6, data_exception=0.
  - busy high for edges E0..E32.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1.
- ctrl_MULT, A=0xFFFFFFFF, B=0x80000000 -> data_result=0x80000000, data_exception=1 (+2^31 overflows).
- ctrl_DIV cases:
  - A=-7, B=2 -> data_result=0xFFFFFFFD, exception=0.
  - A=5, B=0 -> data_result=0, exception=1.
  - A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1.
- Abort by restart: ctrl_MULT A=3, B=4, then 10 edges later ctrl_DIV A=100, B=7.
  - Exactly one RDY strobe, 33 edges after the DIV start.
  - data_result=14, data_exception=0.
  - No strobe carrying 12.
- Reset cases:
  - clr asserted at edge E20 of a multiply -> outputs immediately 0, no RDY.
  - After clr deasserts, ctrl_MULT with both pulses high (ctrl_DIV=1 also), A=2, B=3 -> multiply selected, data_result=6.
